// File: rtl/dm_pipe.sv
// Byte-addressable data memory with a single-outstanding request/response handshake.
// Optional zero-fill sweep after reset; loads and stores complete in one cycle.
module dm_pipe #(
    parameter int DEPTH_BYTES    = 512,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WA    = AW - 2;
    localparam logic [WA-1:0] LAST_W = WA'(WORDS - 1);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

    state_t          state, state_nxt;
    logic [WA-1:0]   init_cnt;
    logic [31:0]     mem [WORDS];

    logic [2:0]      acc_size;
    logic            misalign;
    logic [32:0]     end_addr;
    logic            req_err;
    logic            accept;
    logic [WA-1:0]   widx;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;
    logic [31:0]     load_data;
    logic [3:0]      st_be;
    logic [31:0]     st_data;

    logic [31:0]     rdata_p1;
    logic            err_p1;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        logic signed [7:0]  s;
        logic signed [31:0] r;
        s = b;
        r = s;
        return r;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        logic signed [15:0] s;
        logic signed [31:0] r;
        s = h;
        r = s;
        return r;
    endfunction

    // Access decode: size, alignment and range against the memory end.
    always_comb begin
        acc_size = 3'd1;
        misalign = 1'b0;
        case (req_op)
            OP_LW, OP_SW: begin
                acc_size = 3'd4;
                misalign = |req_addr[1:0];
            end
            OP_LH, OP_LHU, OP_SH: begin
                acc_size = 3'd2;
                misalign = req_addr[0];
            end
            default: ;
        endcase
        end_addr = {1'b0, req_addr} + {30'b0, acc_size};
        req_err  = misalign || (end_addr > 33'(DEPTH_BYTES));
    end

    assign accept   = req_valid && req_ready && !rst;
    assign widx     = req_addr[AW-1:2];
    assign rd_word  = mem[widx];
    assign rd_shift = rd_word >> {req_addr[1:0], 3'b000};

    always_comb begin
        load_data = '0;
        st_be     = 4'b0000;
        st_data   = '0;
        case (req_op)
            OP_LW:  load_data = rd_word;
            OP_LH:  load_data = sext16(rd_shift[15:0]);
            OP_LHU: load_data = {16'b0, rd_shift[15:0]};
            OP_LB:  load_data = sext8(rd_shift[7:0]);
            OP_LBU: load_data = {24'b0, rd_shift[7:0]};
            OP_SW: begin
                st_be   = 4'b1111;
                st_data = req_wdata;
            end
            OP_SH: begin
                st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{req_wdata[15:0]}};
            end
            OP_SB: begin
                st_be   = 4'b0001 << req_addr[1:0];
                st_data = {4{req_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Memory array: sweep writes in INIT, byte-enabled stores on acceptance.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end else if (accept && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem[widx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR_ON_RESET ? INIT : IDLE;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                init_cnt <= init_cnt + WA'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_cnt == LAST_W) state_nxt = IDLE;
            IDLE:    if (req_valid)          state_nxt = RESP;
            RESP:    if (resp_ready)         state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        busy       = (state == INIT);
    end

    // Response stage: captured on the acceptance edge, held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else if (accept) begin
            err_p1   <= req_err;
            rdata_p1 <= req_err ? 32'h0 : load_data;
        end
    end

    assign resp_rdata = rdata_p1;
    assign resp_err   = err_p1;

endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe with a byte-array reference model and a per-cycle output compare.
module tb_dm_pipe;

    localparam int DEPTH = 512;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    dm_pipe #(.DEPTH_BYTES(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0]  mm [DEPTH];
    logic        chk_en = 1'b0;
    logic        exp_busy = 1'b0, exp_ready = 1'b0, exp_valid = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour straight from the access rules, on a byte array.
    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic e);
        int sz;
        sz = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
        e  = ((a % sz) != 0) || (longint'(a) + longint'(sz) > longint'(DEPTH));
        rd = '0;
        if (!e) begin
            case (op)
                LW:  rd = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
                LH:  rd = {{16{mm[a+1][7]}}, mm[a+1], mm[a]};
                LHU: rd = {16'b0, mm[a+1], mm[a]};
                LB:  rd = {{24{mm[a][7]}}, mm[a]};
                LBU: rd = {24'b0, mm[a]};
                default: for (int i = 0; i < sz; i++) mm[a+i] = wd[8*i +: 8];
            endcase
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int sweep);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_busy = 1'b1; exp_ready = 1'b0; exp_valid = 1'b0;
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
        if (sweep < 128) begin
            repeat (sweep) tick();
        end else begin
            repeat (127) tick();
            tick();
            exp_busy = 1'b0; exp_ready = 1'b1;
        end
    endtask

    task automatic xact(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] got, output logic got_err);
        logic [31:0] rd;
        logic        e;
        req_op = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        model(op, a, wd, rd, e);
        exp_valid = 1'b1; exp_ready = 1'b0; exp_rdata = rd; exp_err = e;
        got = resp_rdata; got_err = resp_err;
        repeat (hold) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        exp_valid = 1'b0; exp_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g;
        logic        ge;
        logic [31:0] rd;
        logic        e;

        tick();
        do_reset(128);

        xact(LW, 32'h1FC, 0, 0, g, ge);
        chk("lit_lw_1fc", g, 32'h0);
        chk("lit_lw_1fc_err", 32'(ge), 32'h0);

        xact(SW, 32'h10, 32'h8000FF7F, 0, g, ge);
        chk("lit_sw_rdata", g, 32'h0);
        xact(LB,  32'h10, 0, 1, g, ge); chk("lit_lb",  g, 32'h0000007F);
        xact(LBU, 32'h10, 0, 0, g, ge); chk("lit_lbu", g, 32'h0000007F);
        xact(LH,  32'h12, 0, 0, g, ge); chk("lit_lh",  g, 32'hFFFF8000);
        xact(LHU, 32'h12, 0, 2, g, ge); chk("lit_lhu", g, 32'h00008000);
        xact(LB,  32'h13, 0, 0, g, ge); chk("lit_lb13", g, 32'hFFFFFF80);

        xact(SW, 32'h20, 32'h11223344, 0, g, ge);
        xact(SB, 32'h21, 32'h000000AB, 0, g, ge);
        xact(LW, 32'h20, 0, 0, g, ge); chk("lit_sb_merge", g, 32'h1122AB44);
        xact(SH, 32'h22, 32'hFFFF5A5A, 0, g, ge);
        xact(LW, 32'h20, 0, 0, g, ge); chk("lit_sh_merge", g, 32'h5A5AAB44);

        xact(SW, 32'h00, 32'hCAFEF00D, 0, g, ge);
        xact(SW, 32'h02, 32'hDEADBEEF, 0, g, ge);
        chk("lit_sw02_err", 32'(ge), 32'h1); chk("lit_sw02_rd", g, 32'h0);
        xact(LH, 32'h03, 0, 0, g, ge);
        chk("lit_lh03_err", 32'(ge), 32'h1); chk("lit_lh03_rd", g, 32'h0);
        xact(LW, 32'h200, 0, 0, g, ge);
        chk("lit_lw200_err", 32'(ge), 32'h1); chk("lit_lw200_rd", g, 32'h0);
        xact(LW, 32'h00, 0, 0, g, ge); chk("lit_lw00_kept", g, 32'hCAFEF00D);
        xact(SB, 32'h1FF, 32'h000000C3, 0, g, ge); chk("lit_sb1ff_err", 32'(ge), 32'h0);
        xact(LBU, 32'h1FF, 0, 0, g, ge); chk("lit_lbu1ff", g, 32'h000000C3);
        xact(SH, 32'h1FF, 32'h1234, 0, g, ge); chk("lit_sh1ff_err", 32'(ge), 32'h1);
        xact(LW, 32'hFFFFFFFC, 0, 0, g, ge); chk("lit_lw_wrap_err", 32'(ge), 32'h1);

        // req_valid held through a stalled response: no accept until back in IDLE.
        req_op = LW; req_addr = 32'h20; req_wdata = '0; req_valid = 1'b1;
        tick();
        model(LW, 32'h20, 0, rd, e);
        exp_valid = 1'b1; exp_ready = 1'b0; exp_rdata = rd; exp_err = e;
        repeat (5) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        exp_valid = 1'b0; exp_ready = 1'b1;
        tick();
        exp_valid = 1'b1; exp_ready = 1'b0;
        req_valid = 1'b0;
        chk("lit_reaccept", resp_rdata, 32'h5A5AAB44);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        exp_valid = 1'b0; exp_ready = 1'b1;

        // Reset while a response is pending, then reset in the middle of the sweep.
        xact(SW, 32'h1FC, 32'h12345678, 0, g, ge);
        req_op = LW; req_addr = 32'h1FC; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        model(LW, 32'h1FC, 0, rd, e);
        exp_valid = 1'b1; exp_ready = 1'b0; exp_rdata = rd; exp_err = e;
        chk("lit_lw1fc_pre", resp_rdata, 32'h12345678);
        tick();
        do_reset(40);
        do_reset(128);
        xact(LW, 32'h1FC, 0, 0, g, ge); chk("lit_after_rst_1fc", g, 32'h0);
        xact(LW, 32'h00, 0, 0, g, ge);  chk("lit_after_rst_00", g, 32'h0);
        xact(LW, 32'h20, 0, 0, g, ge);  chk("lit_after_rst_20", g, 32'h0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
